// File: rtl/tlc_pkg.sv
// Shared lamp codes, controller state encoding and small elaboration helpers
// for the multi-approach traffic-light controller.
package tlc_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] DARK   = 2'b11;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin requester search: first set sensor bit after cur_dir, wrapping,
// with cur_dir itself considered last.
module tlc_rr_pick #(
  parameter int unsigned N_DIR = 4
) (
  input  logic [N_DIR-1:0]         sensor,
  input  logic [$clog2(N_DIR)-1:0] cur_dir,
  output logic [$clog2(N_DIR)-1:0] next_dir,
  output logic                     any_req
);

  localparam int unsigned DW = $clog2(N_DIR);

  logic [N_DIR-1:0] rot;
  logic [DW-1:0]    src;
  logic [DW-1:0]    pick;

  // Rotate so bit 0 is the approach right after cur_dir, pick lowest, un-rotate.
  always_comb begin
    rot  = '0;
    src  = '0;
    pick = '0;
    for (int i = 0; i < int'(N_DIR); i++) begin
      src    = DW'((int'(cur_dir) + 1 + i) % int'(N_DIR));
      rot[i] = sensor[src];
    end
    for (int i = int'(N_DIR) - 1; i >= 0; i--) begin
      if (rot[i]) pick = DW'(i);
    end
    next_dir = DW'((int'(cur_dir) + 1 + int'(pick)) % int'(N_DIR));
    any_req  = |sensor;
  end

endmodule

// File: rtl/tlc_multiway.sv
// N-approach traffic-light controller: demand-driven round-robin service with
// min/max green, yellow and all-red clearance, plus a maintenance flash mode.
module tlc_multiway
  import tlc_pkg::*;
#(
  parameter int unsigned N_DIR      = 4,
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MAX_GREEN  = 16,
  parameter int unsigned YELLOW_CYC = 2,
  parameter int unsigned ALLRED_CYC = 1,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_DIR-1:0]         sensor,
  input  logic                     flash,
  output logic [2*N_DIR-1:0]       lights,
  output logic [$clog2(N_DIR)-1:0] cur_dir,
  output logic                     in_flash
);

  localparam int unsigned DW     = $clog2(N_DIR);
  localparam int unsigned T_SPAN = max2(max2(MAX_GREEN, ALLRED_CYC), max2(YELLOW_CYC, 2 * FLASH_HALF));
  localparam int unsigned TW     = $clog2(T_SPAN) + 1;

  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] FL_HALF  = TW'(FLASH_HALF);
  localparam logic [TW-1:0] FL_LAST  = TW'(2 * FLASH_HALF - 1);

  if (N_DIR < 2) begin : g_chk_ndir
    $error("tlc_multiway: N_DIR must be >= 2");
  end
  if (MIN_GREEN < 1) begin : g_chk_min
    $error("tlc_multiway: MIN_GREEN must be >= 1");
  end
  if (MAX_GREEN < MIN_GREEN) begin : g_chk_max
    $error("tlc_multiway: MAX_GREEN must be >= MIN_GREEN");
  end
  if (YELLOW_CYC < 1) begin : g_chk_yel
    $error("tlc_multiway: YELLOW_CYC must be >= 1");
  end
  if (ALLRED_CYC < 1) begin : g_chk_ar
    $error("tlc_multiway: ALLRED_CYC must be >= 1");
  end
  if (FLASH_HALF < 1) begin : g_chk_fl
    $error("tlc_multiway: FLASH_HALF must be >= 1");
  end

  state_e             state;
  logic [TW-1:0]      timer;

  state_e             nxt_state;
  logic [TW-1:0]      nxt_timer;
  logic [DW-1:0]      nxt_dir;
  logic [2*N_DIR-1:0] nxt_lights;
  logic [TW-1:0]      timer_inc;
  logic [DW-1:0]      pick_dir;
  logic               any_req;
  logic               other_demand;

  tlc_rr_pick #(.N_DIR(N_DIR)) u_pick (
    .sensor   (sensor),
    .cur_dir  (cur_dir),
    .next_dir (pick_dir),
    .any_req  (any_req)
  );

  assign timer_inc = (timer == '1) ? timer : timer + TW'(1);

  always_comb begin
    other_demand = 1'b0;
    for (int i = 0; i < int'(N_DIR); i++) begin
      if (DW'(i) != cur_dir) other_demand = other_demand | sensor[i];
    end
  end

  // Next-state, next-timer and next-direction decisions.
  always_comb begin
    nxt_state = state;
    nxt_timer = timer_inc;
    nxt_dir   = cur_dir;
    unique case (state)
      ST_ALLRED: begin
        if (timer >= AR_LAST) begin
          if (flash) begin
            nxt_state = ST_FLASH;
            nxt_timer = '0;
          end else if (any_req) begin
            nxt_state = ST_GREEN;
            nxt_timer = '0;
            nxt_dir   = pick_dir;
          end
        end
      end
      ST_GREEN: begin
        if ((timer >= MIN_LAST) &&
            (flash || (other_demand && (!sensor[cur_dir] || (timer >= MAX_LAST))))) begin
          nxt_state = ST_YELLOW;
          nxt_timer = '0;
        end
      end
      ST_YELLOW: begin
        if (timer >= YEL_LAST) begin
          nxt_state = ST_ALLRED;
          nxt_timer = '0;
        end
      end
      ST_FLASH: begin
        if (!flash) begin
          nxt_state = ST_ALLRED;
          nxt_timer = '0;
        end else if (timer >= FL_LAST) begin
          nxt_timer = '0;
        end
      end
    endcase
  end

  // Lamp decode of the upcoming state so the lamp register tracks the state register.
  always_comb begin
    nxt_lights = {N_DIR{RED}};
    for (int i = 0; i < int'(N_DIR); i++) begin
      if (nxt_state == ST_FLASH) begin
        nxt_lights[2*i +: 2] = (nxt_timer < FL_HALF) ? RED : DARK;
      end else if (DW'(i) == nxt_dir && nxt_state == ST_GREEN) begin
        nxt_lights[2*i +: 2] = GREEN;
      end else if (DW'(i) == nxt_dir && nxt_state == ST_YELLOW) begin
        nxt_lights[2*i +: 2] = YELLOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ALLRED;
      timer    <= '0;
      cur_dir  <= DW'(N_DIR - 1);
      lights   <= {N_DIR{RED}};
      in_flash <= 1'b0;
    end else begin
      state    <= nxt_state;
      timer    <= nxt_timer;
      cur_dir  <= nxt_dir;
      lights   <= nxt_lights;
      in_flash <= (nxt_state == ST_FLASH);
    end
  end

endmodule

// File: doc/tlc_multiway.md
# tlc_multiway

Parametrised N-approach traffic-light controller and the successor to the two-road sensor controller. It serves any number of approaches round-robin with demand-driven skipping. Green time is bounded by minimum and maximum limits, and yellow and all-red clearance durations are configurable. It adds a maintenance flash mode. The block sits at intersection top level, between debounced vehicle sensors and the lamp drivers.

## Interface
- N_DIR, 4: number of approaches; must be ≥ 2.
- MIN_GREEN, 4: minimum green cycles; must be ≥ 1.
- MAX_GREEN, 16: maximum green cycles when another approach has demand; must be ≥ MIN_GREEN.
- YELLOW_CYC, 2: yellow cycles; must be ≥ 1.
- ALLRED_CYC, 1: all-red clearance cycles; must be ≥ 1.
- FLASH_HALF, 4: half-period of the flash pattern, in cycles; must be ≥ 1.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- sensor  in  N_DIR  bit i set means vehicle demand on approach i; sampled synchronously.
- flash  in  1  maintenance-flash request, level-sensitive.
- lights  out  2*N_DIR  lamp code of approach i is in bits [2i+1:2i]; 00 green, 01 yellow, 10 red, 11 dark.
- cur_dir  out  clog2(N_DIR)  index of the approach last granted green.
- in_flash  out  1  high while in the FLASH state.

## Operation
- The block has four states: ALLRED, GREEN, YELLOW, FLASH.
- A timer counts cycles spent in the current state and clears on every state transition.
- Reset values:
  - state = ALLRED, timer = 0, cur_dir = N_DIR-1, in_flash = 0.
  - lights = all approaches 10 (red).
- other_demand means the sensor bit is set for any index other than cur_dir.
- ALLRED: all approaches show red.
  - Leaving requires timer ≥ ALLRED_CYC-1.
  - If flash is high, go to FLASH.
  - Otherwise, if any sensor bit is set, go to GREEN. The new cur_dir is the first set bit found searching cyclically from cur_dir+1; cur_dir itself is checked last.
  - If no sensor bit is set, stay in ALLRED. This is rest-on-red; the timer saturates.
- GREEN: approach cur_dir shows 00 and all other approaches show 10. Go to YELLOW when timer ≥ MIN_GREEN-1 and any of the following holds:
  - flash is high; or
  - other_demand is set and sensor[cur_dir] is clear; or
  - other_demand is set and timer ≥ MAX_GREEN-1 (forced change).
  - With no other_demand and no flash, green holds indefinitely (rest-on-green).
- YELLOW: approach cur_dir shows 01 and the rest show 10. After YELLOW_CYC cycles, go to ALLRED.
- FLASH: in_flash is 1.
  - All approaches show 10 for FLASH_HALF cycles, then 11 for FLASH_HALF cycles, repeating. The phase starts at red on entry.
  - When flash deasserts, go to ALLRED for the full clearance time. cur_dir is unchanged.
- Timer width is clog2(max(MAX_GREEN, ALLRED_CYC, YELLOW_CYC, 2*FLASH_HALF)) + 1. It never wraps; it saturates at its maximum value.
- Simultaneous events:
  - flash rising during YELLOW or ALLRED takes effect at the next ALLRED exit.
  - A sensor change in the same cycle as a decision is acted on by that decision, because decisions use the current-cycle sensor.
- Reset asserted mid-operation: all outputs immediately return to their reset values, with no yellow phase.

## Timing
- Outputs are a Moore decode of registered state, timer and cur_dir; there is no combinational path from the inputs to the outputs.
- A state change appears on lights in the cycle after the decision edge.
- Minimum full rotation step: MIN_GREEN + YELLOW_CYC + ALLRED_CYC cycles.
- After rst_n deasserts with a sensor already present, the first green appears ALLRED_CYC cycles later.
- Flash entry latency, worst case from a GREEN start: MIN_GREEN + YELLOW_CYC + ALLRED_CYC cycles.

## Structure
- Package tlc_pkg holds:
  - the lamp code constants GREEN=2'b00, YELLOW=2'b01, RED=2'b10, DARK=2'b11;
  - the state enum.
- Sub-module tlc_rr_pick, purely combinational:
  - inputs: sensor and cur_dir;
  - outputs: next index and an any-request flag;
  - search order: rotate, priority-pick, un-rotate.
- Top-level elaboration checks: the parameter constraints listed under Interface.

## Test plan
All scenarios use N_DIR=4, MIN_GREEN=4, MAX_GREEN=8, YELLOW_CYC=2, ALLRED_CYC=1, FLASH_HALF=2.
- Reset with sensor=0: lights = 8'b10101010, held for more than 50 cycles. Then pulse rst_n low mid-yellow: lights return to all red on the same edge.
- sensor=4'b0100 from reset: after 1 all-red cycle, cur_dir=2 and lights = 8'b10001010. Green holds for more than 30 cycles with no other demand.
- Approach 2 in green, sensor[0] set at green cycle 1, sensor[2] clear: exactly 4 green cycles, 2 yellow (lights[5:4]=01), 1 all-red, then approach 0 green.
- sensor = 4'b0101 held constant with approach 2 green: exactly 8 green cycles, then approach 0 served next.
- cur_dir=1 with sensor=4'b1001: next green goes to approach 3, then to approach 0, and approach 2 is skipped.
- flash raised at green cycle 0: yellow after 4 green cycles, then all-red, then lights alternate all-red and all-dark every 2 cycles with in_flash=1. After flash drops: 1 all-red cycle, then green resumes in round-robin order.
